sat_accum_ctrl: RTL and testbench
=================================

Name: sat_accum_ctrl

Overview:
- Sequencer that drives one shared 16-bit signed saturating add/sub datapath to reduce a stream of 1..MAX_OPS operands into a single accumulated result.
- Used for multi-operand reductions (RED-style ops, checksum/dot-sum passes) so the core needs no adder tree.
- Provides a start/busy/done command interface, a valid/ready operand stream, and registered N/Z/V flags for the flag register.

Parameters:
- MAX_OPS, 8, maximum operands per command; larger num_ops is clamped to MAX_OPS.
- CW, 4, width of num_ops and the internal counter; must satisfy 2^CW > MAX_OPS.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  command strobe; sampled only in IDLE or DONE.
- num_ops  input  CW  operand count, sampled with start.
- sub_mode  input  1  sampled with start; 0 = acc+data, 1 = acc-data for every operand.
- in_valid  input  1  operand valid.
- in_data  input  16  signed operand.
- in_ready  output  1  operand accepted when in_valid&in_ready.
- busy  output  1  command in progress.
- done  output  1  one-cycle completion pulse.
- acc  output  16  registered signed accumulator/result.
- flag_N  output  1  acc[15] of the final result.
- flag_Z  output  1  final result == 0.
- flag_V  output  1  sticky: saturation occurred on any step of the command.

Behaviour:
- Reset (synchronous): state=IDLE; acc=16'h0000; flag_N=0, flag_Z=0, flag_V=0; busy=0, done=0, in_ready=0; counter=0.
  - Reset mid-command aborts the command and discards any partial result.
  - Reset dominates start and in_valid in the same cycle.
- States: IDLE, ACCUM, DONE. All outputs are registered or decoded from state only; no combinational path from inputs to outputs.
- IDLE or DONE with start=1:
  - Latch sub_mode and n = min(num_ops, MAX_OPS). Clear acc to 0 and clear the sticky V.
  - If n=0, go to DONE next cycle: acc=0, flag_Z=1, flag_N=0, flag_V=0.
  - Otherwise go to ACCUM with counter=n.
- IDLE or DONE with start=0: DONE returns to IDLE; IDLE holds.
- ACCUM:
  - busy=1 and in_ready=1.
  - On each transfer (in_valid&in_ready):
    - acc <= sat(acc + in_data) when sub_mode=0.
    - acc <= sat(acc - in_data) when sub_mode=1.
    - Decrement counter.
  - No transfer means no change; bubbles of any length are allowed.
  - The transfer that brings the counter to 0 moves the state to DONE next cycle.
  - Throughput is one operand per cycle. done rises in the cycle after the last accepted operand.
  - start is ignored in ACCUM (no restart, no error).
- Arithmetic:
  - Exact 17-bit signed result, clamped to [-32768, +32767]: positive overflow gives 16'h7FFF, negative overflow gives 16'h8000.
  - Subtract computes the mathematically exact acc-data. For example, 0 - (-32768) saturates to 16'h7FFF; negating 16'h8000 must not wrap.
  - flag_V |= (clamp occurred) on each step. Saturated acc feeds the next step; there is no wrap recovery.
- DONE:
  - Lasts exactly one cycle, unless start is asserted in that cycle, which begins a new command back-to-back.
  - done=1, busy=0, in_ready=0.
  - flag_N and flag_Z are updated from the final acc on entry to DONE. flag_V holds the sticky value.
- acc and the flags hold their values after DONE until the next accepted start or reset.
- in_ready is 0 outside ACCUM. in_valid outside ACCUM is ignored and has no side effects.

Test Plan:
- Reset, then start with num_ops=3, sub_mode=0, operands 5, 7, -2 back-to-back → in_ready for 3 cycles; done exactly 1 cycle after the 3rd transfer; acc=10, N=0, Z=0, V=0.
- num_ops=2, sub_mode=0, operands 16'h7000, 16'h2000, with in_valid bubbles of 2 cycles between them → acc=16'h7FFF, V=1, N=0; done after the 2nd transfer only.
- num_ops=2, sub_mode=1, operands 16'h8000 then 16'h0001 → step 1 gives 16'h7FFF (V=1); step 2 gives 16'h7FFE; final acc=16'h7FFE, V=1 (sticky), N=0.
- num_ops=0 → done in the next cycle, in_ready never asserted, acc=0, Z=1; num_ops=15 with MAX_OPS=8 → exactly 8 operands accepted.
- start pulsed during ACCUM is ignored; start asserted in the DONE cycle (num_ops=1, operand -4) → new command runs with acc cleared; acc=16'hFFFC, N=1, V=0.
- rst asserted after 2 of 4 operands → next cycle IDLE, acc=0, all flags 0, in_ready=0; a following command computes correctly from 0.

Source files
------------

// File: rtl/sat_accum_ctrl.sv
// Sequencer that reduces a stream of 1..MAX_OPS signed 16-bit operands through one
// shared saturating add/sub step, with start/busy/done control and N/Z/V result flags.
module sat_accum_ctrl #(
   parameter int MAX_OPS = 8,
   parameter int CW      = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [CW-1:0] num_ops,
   input  logic          sub_mode,
   input  logic          in_valid,
   input  logic [15:0]   in_data,
   output logic          in_ready,
   output logic          busy,
   output logic          done,
   output logic [15:0]   acc,
   output logic          flag_N,
   output logic          flag_Z,
   output logic          flag_V,
   output logic [1:0]    state_dbg
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ACCUM = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   localparam logic [CW-1:0] MAX_N = CW'(MAX_OPS);

   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic          sub_lat;
   logic [CW-1:0] n_clamped;
   logic [16:0]   wide;
   logic [15:0]   sat_res;
   logic          clamped;
   logic          xfer;

   // Handshake: an operand moves on a cycle where in_valid and in_ready are both high;
   // in_ready is decoded from state alone, so it never depends on in_valid.
   assign in_ready  = (state == ACCUM);
   assign busy      = (state == ACCUM);
   assign done      = (state == DONE);
   assign state_dbg = state;
   assign xfer      = in_valid && in_ready;

   assign n_clamped = (num_ops > MAX_N) ? MAX_N : num_ops;

   // Exact 17-bit result; bits 16 and 15 disagree exactly when 16 bits cannot hold it.
   always_comb begin
      wide    = 17'd0;
      sat_res = 16'h0000;
      clamped = 1'b0;
      if (sub_lat) wide = {acc[15], acc} - {in_data[15], in_data};
      else         wide = {acc[15], acc} + {in_data[15], in_data};
      if (wide[16] != wide[15]) begin
         clamped = 1'b1;
         sat_res = wide[16] ? 16'h8000 : 16'h7FFF;
      end else begin
         sat_res = wide[15:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         sub_lat <= 1'b0;
         acc     <= 16'h0000;
         flag_N  <= 1'b0;
         flag_Z  <= 1'b0;
         flag_V  <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  sub_lat <= sub_mode;
                  acc     <= 16'h0000;
                  flag_V  <= 1'b0;
                  cnt     <= n_clamped;
                  if (n_clamped == '0) begin
                     state  <= DONE;
                     flag_N <= 1'b0;
                     flag_Z <= 1'b1;
                  end else begin
                     state <= ACCUM;
                  end
               end else begin
                  state <= IDLE;
               end
            end
            ACCUM: begin
               if (xfer) begin
                  acc    <= sat_res;
                  flag_V <= flag_V | clamped;
                  cnt    <= cnt - CW'(1);
                  if (cnt == CW'(1)) begin
                     state  <= DONE;
                     flag_N <= sat_res[15];
                     flag_Z <= (sat_res == 16'h0000);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sat_accum_ctrl.sv
// Directed bench for sat_accum_ctrl: a table of reduction commands with hand-computed
// results, plus hand-written sequences for restart-in-DONE, start-in-ACCUM and mid-command reset.
module tb_sat_accum_ctrl;

   logic        clk;
   logic        rst;
   logic        start;
   logic [3:0]  num_ops;
   logic        sub_mode;
   logic        in_valid;
   logic [15:0] in_data;
   logic        in_ready;
   logic        busy;
   logic        done;
   logic [15:0] acc;
   logic        flag_N;
   logic        flag_Z;
   logic        flag_V;
   logic [1:0]  state_dbg;

   int checks = 0;
   int errors = 0;

   logic [15:0] exp_q[$];

   typedef struct {
      logic [3:0]  num_ops;
      logic        sub;
      int          n_data;
      int          bubble;
      logic [15:0] d[8];
      logic [15:0] exp_acc;
      logic        exp_n;
      logic        exp_z;
      logic        exp_v;
   } vec_t;

   vec_t vecs[8];

   sat_accum_ctrl #(.MAX_OPS(8), .CW(4)) dut (
      .clk(clk), .rst(rst), .start(start), .num_ops(num_ops), .sub_mode(sub_mode),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .busy(busy),
      .done(done), .acc(acc), .flag_N(flag_N), .flag_Z(flag_Z), .flag_V(flag_V),
      .state_dbg(state_dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle_after_reset();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_acc", acc, 16'h0000);
      chk("rst_N", flag_N, 0);
      chk("rst_Z", flag_Z, 0);
      chk("rst_V", flag_V, 0);
      chk("rst_state", state_dbg, 2'd0);
   endtask

   task automatic run_vec(input vec_t v);
      exp_q.push_back(v.exp_acc);
      start = 1'b1; num_ops = v.num_ops; sub_mode = v.sub; in_valid = 1'b0;
      tick();
      start = 1'b0;
      for (int i = 0; i < v.n_data; i++) begin
         for (int b = 0; b < v.bubble; b++) begin
            in_valid = 1'b0;
            chk("bubble_ready", in_ready, 1);
            chk("bubble_done", done, 0);
            tick();
         end
         chk("in_ready", in_ready, 1);
         chk("busy", busy, 1);
         chk("early_done", done, 0);
         in_valid = 1'b1; in_data = v.d[i];
         tick();
      end
      // Operand offered in DONE and the following IDLE must be ignored.
      in_valid = 1'b1; in_data = 16'h1111;
      chk("done", done, 1);
      chk("done_busy", busy, 0);
      chk("done_in_ready", in_ready, 0);
      chk("acc", acc, exp_q.pop_front());
      chk("flag_N", flag_N, v.exp_n);
      chk("flag_Z", flag_Z, v.exp_z);
      chk("flag_V", flag_V, v.exp_v);
      tick();
      chk("done_pulse_end", done, 0);
      chk("idle_in_ready", in_ready, 0);
      chk("acc_hold", acc, v.exp_acc);
      chk("flag_V_hold", flag_V, v.exp_v);
      in_valid = 1'b0;
   endtask

   initial begin
      foreach (vecs[k]) begin
         vecs[k].bubble = 0;
         foreach (vecs[k].d[j]) vecs[k].d[j] = 16'h0000;
      end
      // 5 + 7 - 2 = 10
      vecs[0].num_ops = 4'd3; vecs[0].sub = 0; vecs[0].n_data = 3;
      vecs[0].d[0] = 16'd5; vecs[0].d[1] = 16'd7; vecs[0].d[2] = 16'hFFFE;
      vecs[0].exp_acc = 16'd10; vecs[0].exp_n = 0; vecs[0].exp_z = 0; vecs[0].exp_v = 0;
      // 0x7000 + 0x2000 overflows positive, with 2-cycle bubbles
      vecs[1].num_ops = 4'd2; vecs[1].sub = 0; vecs[1].n_data = 2; vecs[1].bubble = 2;
      vecs[1].d[0] = 16'h7000; vecs[1].d[1] = 16'h2000;
      vecs[1].exp_acc = 16'h7FFF; vecs[1].exp_n = 0; vecs[1].exp_z = 0; vecs[1].exp_v = 1;
      // 0 - (-32768) clamps to 0x7FFF, then -1 gives 0x7FFE, V sticky
      vecs[2].num_ops = 4'd2; vecs[2].sub = 1; vecs[2].n_data = 2;
      vecs[2].d[0] = 16'h8000; vecs[2].d[1] = 16'h0001;
      vecs[2].exp_acc = 16'h7FFE; vecs[2].exp_n = 0; vecs[2].exp_z = 0; vecs[2].exp_v = 1;
      // num_ops=15 clamps to 8 operands: 1+2+...+8 = 36
      vecs[3].num_ops = 4'd15; vecs[3].sub = 0; vecs[3].n_data = 8;
      for (int j = 0; j < 8; j++) vecs[3].d[j] = 16'(j + 1);
      vecs[3].exp_acc = 16'h0024; vecs[3].exp_n = 0; vecs[3].exp_z = 0; vecs[3].exp_v = 0;
      // num_ops=0: immediate DONE with Z
      vecs[4].num_ops = 4'd0; vecs[4].sub = 0; vecs[4].n_data = 0;
      vecs[4].exp_acc = 16'h0000; vecs[4].exp_n = 0; vecs[4].exp_z = 1; vecs[4].exp_v = 0;
      // 0 - 100 - 50 - 50 = -200
      vecs[5].num_ops = 4'd3; vecs[5].sub = 1; vecs[5].n_data = 3; vecs[5].bubble = 1;
      vecs[5].d[0] = 16'd100; vecs[5].d[1] = 16'd50; vecs[5].d[2] = 16'd50;
      vecs[5].exp_acc = 16'hFF38; vecs[5].exp_n = 1; vecs[5].exp_z = 0; vecs[5].exp_v = 0;
      // -32768 + -1 clamps negative
      vecs[6].num_ops = 4'd2; vecs[6].sub = 0; vecs[6].n_data = 2;
      vecs[6].d[0] = 16'h8000; vecs[6].d[1] = 16'hFFFF;
      vecs[6].exp_acc = 16'h8000; vecs[6].exp_n = 1; vecs[6].exp_z = 0; vecs[6].exp_v = 1;
      // 0x1234 + 0xEDCC = 0 exactly
      vecs[7].num_ops = 4'd2; vecs[7].sub = 0; vecs[7].n_data = 2;
      vecs[7].d[0] = 16'h1234; vecs[7].d[1] = 16'hEDCC;
      vecs[7].exp_acc = 16'h0000; vecs[7].exp_n = 0; vecs[7].exp_z = 1; vecs[7].exp_v = 0;

      rst = 1'b1; start = 1'b0; num_ops = '0; sub_mode = 1'b0; in_valid = 1'b0; in_data = '0;
      tick();
      tick();
      check_idle_after_reset();
      rst = 1'b0;
      tick();

      foreach (vecs[k]) run_vec(vecs[k]);

      // start pulsed in ACCUM is ignored; start in the DONE cycle restarts with cleared acc/V
      start = 1'b1; num_ops = 4'd2; sub_mode = 1'b0;
      tick();
      start = 1'b1; num_ops = 4'd1; sub_mode = 1'b1;
      in_valid = 1'b1; in_data = 16'h7FFF;
      tick();
      start = 1'b0;
      chk("accum_start_busy", busy, 1);
      in_data = 16'h0001;
      tick();
      in_valid = 1'b0;
      chk("b2b_done1", done, 1);
      chk("b2b_acc1", acc, 16'h7FFF);
      chk("b2b_V1", flag_V, 1);
      start = 1'b1; num_ops = 4'd1; sub_mode = 1'b0;
      tick();
      start = 1'b0;
      chk("b2b_busy", busy, 1);
      chk("b2b_done_low", done, 0);
      chk("b2b_acc_clear", acc, 16'h0000);
      chk("b2b_V_clear", flag_V, 0);
      in_valid = 1'b1; in_data = 16'hFFFC;
      tick();
      in_valid = 1'b0;
      chk("b2b_done2", done, 1);
      chk("b2b_acc2", acc, 16'hFFFC);
      chk("b2b_N2", flag_N, 1);
      chk("b2b_Z2", flag_Z, 0);
      chk("b2b_V2", flag_V, 0);
      tick();

      // Reset after 2 of 4 operands, asserted alongside start and in_valid
      start = 1'b1; num_ops = 4'd4; sub_mode = 1'b0;
      tick();
      start = 1'b0;
      in_valid = 1'b1; in_data = 16'h7FF0;
      tick();
      in_data = 16'h0100;
      tick();
      chk("pre_rst_V", flag_V, 1);
      rst = 1'b1; start = 1'b1; in_data = 16'h0005;
      tick();
      rst = 1'b0; start = 1'b0; in_valid = 1'b0;
      check_idle_after_reset();
      tick();
      chk("post_rst_idle", state_dbg, 2'd0);
      run_vec(vecs[0]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
